pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have one clock and reset, stated as: CLK is the single clock; RST is synchronous, active-high.
REQ-002 Parameter TICK_DIV SHALL default to 4096 and set the number of CLK cycles per sample tick (range 2..65536).
REQ-003 Parameter PERIOD SHALL default to 256 and set the nominal PWM period in ticks.
REQ-004 Parameter TOL SHALL default to 1 and set the allowed period deviation in ticks.
REQ-005 Ports SHALL be, in order:
- CLK  in  1  system clock
- RST  in  1  sync reset, active-high
- PORT_IN  in  1  asynchronous PWM input
- DATA_OUT  out  8  decoded duty value
- DATA_VALID  out  1  one-CLK strobe per decoded frame
- ERR  out  1  one-CLK strobe, period out of tolerance

Function
REQ-006 PORT_IN SHALL pass through a 2-flop synchroniser clocked by CLK before any other use.
REQ-007 A prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick for one CLK cycle when it wraps to 0.
REQ-008 The synchronised input SHALL be sampled only on tick cycles; all edge detection SHALL compare the current tick sample with the previous tick sample.
REQ-009 The FSM SHALL have the states IDLE, HIGH and LOW:
- IDLE: wait for a rising edge -> HIGH, with hi_cnt=1 and per_cnt=1.
- HIGH: each tick sampled high increments hi_cnt and per_cnt; a falling edge -> LOW, with per_cnt incremented.
- LOW: each low tick increments per_cnt; a rising edge closes the frame.
REQ-010 On frame close, the block SHALL on the same tick:
- set DATA_OUT = min(hi_cnt, 255);
- pulse DATA_VALID for one CLK;
- restart the next frame in HIGH, with hi_cnt=1 and per_cnt=1.
REQ-011 Output latency SHALL be 3 CLK cycles or fewer after the closing tick.
REQ-012 Timeout: if per_cnt reaches PERIOD+TOL+1 in LOW, or in IDLE with the input low, the block SHALL set DATA_OUT=0, pulse DATA_VALID and enter IDLE. The IDLE timeout counter SHALL repeat this every PERIOD+TOL+1 ticks.
REQ-013 Timeout in HIGH, or in IDLE with the input high, SHALL set DATA_OUT=255, pulse DATA_VALID and enter IDLE.
REQ-014 Counters hi_cnt and per_cnt SHALL be wide enough to hold PERIOD+TOL+1 and SHALL saturate, never wrap.
REQ-015 DATA_OUT SHALL hold its last value between DATA_VALID pulses.
REQ-016 DATA_VALID and ERR SHALL never be high for more than one consecutive CLK.

Reset
REQ-017 While RST is high, the block SHALL:
- set DATA_OUT=0, DATA_VALID=0 and ERR=0;
- clear the prescaler, counters, synchroniser and previous-sample flops;
- put the FSM in IDLE.
REQ-018 RST asserted mid-frame SHALL discard the partial frame; no DATA_VALID SHALL be produced for it.
REQ-019 After RST deasserts, the first tick SHALL occur TICK_DIV CLK cycles later.

Configuration
REQ-020 The optional feature SHALL be controlled by macro PWM_CAPTURE_PERIOD_CHECK_EN.
REQ-021 When the macro is defined, ERR SHALL pulse together with DATA_VALID on frame close if |per_cnt-PERIOD| > TOL. DATA_OUT SHALL still update. Timeout frames SHALL also pulse ERR.
REQ-022 When the macro is undefined, ERR SHALL be tied to 0 and no period comparison logic SHALL exist.

Verification (TICK_DIV=4, PERIOD=256, TOL=1)
REQ-023 Input with 64 ticks high, 192 low, repeating -> DATA_VALID once per 256 ticks with DATA_OUT=64 from the second rising edge on; ERR=0.
REQ-024 Input constant low for 600 ticks -> DATA_VALID at tick 258 with DATA_OUT=0, repeating every 258 ticks; with the macro, ERR pulses each time.
REQ-025 Input with 255 high, 1 low -> DATA_OUT=255 each frame; constant high -> timeout DATA_OUT=255.
REQ-026 Frame with 300-tick period (100 high) -> timeout in LOW with DATA_OUT=0. A 250-tick period (100 high) -> DATA_OUT=100; with the macro ERR=1, without it ERR=0.
REQ-027 RST pulsed at tick 100 of a 128-high frame -> no DATA_VALID for that frame, all outputs 0. The next complete frame decodes DATA_OUT=128.
REQ-028 A one-CLK glitch on PORT_IN between ticks -> no change in DATA_OUT.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: decodes the duty of a slow PWM input into an 8-bit value.
// The input is synchronised, sampled once per prescaler tick, and each high/low
// frame is measured in ticks. A frame that never closes times out with 0 or 255.
// Optional build macro: PWM_CAPTURE_PERIOD_CHECK_EN adds an ERR strobe for
// frames whose period lies outside PERIOD +/- TOL, and for timeout frames.
module pwm_capture #(
   parameter int unsigned TICK_DIV = 4096,
   parameter int unsigned PERIOD   = 256,
   parameter int unsigned TOL      = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PORT_IN,
   output logic [7:0] DATA_OUT,
   output logic       DATA_VALID,
   output logic       ERR
);

   localparam int unsigned LIMIT = PERIOD + TOL + 1;
   localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW    = $clog2(LIMIT + 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t          state;
   logic [PW-1:0]   pre_cnt;
   logic            tick;
   logic            sync_q1;
   logic            sync_q2;
   logic            prev_s;
   logic [CW-1:0]   hi_cnt;
   logic [CW-1:0]   per_cnt;

   logic [CW-1:0]   hi_inc_c;
   logic [CW-1:0]   per_inc_c;
   logic            rise_c;
   logic            per_to_c;
   logic            timeout_c;
   logic            close_c;
   logic [7:0]      hi_sat_c;

   // Two-flop synchroniser for the asynchronous PWM input
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= PORT_IN;
         sync_q2 <= sync_q1;
      end
   end

   // Prescaler: one-cycle tick each time the count wraps back to zero
   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= (pre_cnt == PW'(TICK_DIV - 1));
         if (pre_cnt == PW'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
         end
      end
   end

   // Saturating increments, edge detection and frame events for the current tick
   always_comb begin
      hi_inc_c  = (hi_cnt  == CW'(LIMIT)) ? hi_cnt  : hi_cnt  + CW'(1);
      per_inc_c = (per_cnt == CW'(LIMIT)) ? per_cnt : per_cnt + CW'(1);
      rise_c    = tick && sync_q2 && !prev_s;
      per_to_c  = (per_inc_c == CW'(LIMIT));
      timeout_c = tick && per_to_c && !rise_c;
      close_c   = (state == LOW) && rise_c;
      hi_sat_c  = (32'(hi_cnt) > 32'd255) ? 8'hFF : 8'(hi_cnt);
   end

   // Frame FSM with registered duty value and valid strobe
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         hi_cnt     <= '0;
         per_cnt    <= '0;
         prev_s     <= 1'b0;
         DATA_OUT   <= 8'h00;
         DATA_VALID <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         if (tick) begin
            prev_s <= sync_q2;
            case (state)
               IDLE: begin
                  if (rise_c) begin
                     state   <= HIGH;
                     hi_cnt  <= CW'(1);
                     per_cnt <= CW'(1);
                  end else if (timeout_c) begin
                     // Idle timeout repeats; the reported value follows the stuck level
                     DATA_OUT   <= sync_q2 ? 8'hFF : 8'h00;
                     DATA_VALID <= 1'b1;
                     per_cnt    <= '0;
                  end else begin
                     per_cnt <= per_inc_c;
                  end
               end
               HIGH: begin
                  if (timeout_c) begin
                     DATA_OUT   <= 8'hFF;
                     DATA_VALID <= 1'b1;
                     state      <= IDLE;
                     hi_cnt     <= '0;
                     per_cnt    <= '0;
                  end else if (sync_q2) begin
                     hi_cnt  <= hi_inc_c;
                     per_cnt <= per_inc_c;
                  end else begin
                     state   <= LOW;
                     per_cnt <= per_inc_c;
                  end
               end
               LOW: begin
                  if (close_c) begin
                     // Rising edge closes this frame and opens the next one
                     DATA_OUT   <= hi_sat_c;
                     DATA_VALID <= 1'b1;
                     state      <= HIGH;
                     hi_cnt     <= CW'(1);
                     per_cnt    <= CW'(1);
                  end else if (timeout_c) begin
                     DATA_OUT   <= 8'h00;
                     DATA_VALID <= 1'b1;
                     state      <= IDLE;
                     hi_cnt     <= '0;
                     per_cnt    <= '0;
                  end else begin
                     per_cnt <= per_inc_c;
                  end
               end
               default: begin
                  state   <= IDLE;
                  hi_cnt  <= '0;
                  per_cnt <= '0;
               end
            endcase
         end
      end
   end

`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
   logic period_bad_c;
   logic err_q;

   // Closed period outside PERIOD +/- TOL; compared in 32 bits to avoid underflow
   always_comb begin
      period_bad_c = (32'(per_cnt) > PERIOD + TOL) || (32'(per_cnt) + TOL < PERIOD);
   end

   // Error strobe aligned with the DATA_VALID it qualifies
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (close_c && period_bad_c) || timeout_c;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TICK_DIV=4, PERIOD=256, TOL=1.
// Honours PWM_CAPTURE_PERIOD_CHECK_EN for the expected ERR values.
module tb_pwm_capture;

   localparam int unsigned TD  = 4;
   localparam int unsigned PER = 256;
   localparam int unsigned TL  = 1;
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       PORT_IN = 1'b0;
   logic [7:0] DATA_OUT;
   logic       DATA_VALID;
   logic       ERR;

   int passed = 0;
   int total  = 0;
   int base   = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] d;
      logic       e;
      int         c;
   } ev_t;
   ev_t evq[$];

   logic dv_d = 1'b0;
   logic er_d = 1'b0;
   int   dv_double = 0;
   int   er_double = 0;
   int   err_alone = 0;

   pwm_capture #(.TICK_DIV(TD), .PERIOD(PER), .TOL(TL)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PORT_IN    (PORT_IN),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .ERR        (ERR)
   );

   always #5 CLK = ~CLK;

   // Cycles since reset release: edge k after release leaves cyc == k
   always @(posedge CLK) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Output monitor on the falling edge: records frames and strobe widths
   always @(negedge CLK) begin
      if (RST !== 1'b1 && DATA_VALID === 1'b1) evq.push_back('{DATA_OUT, ERR, cyc});
      if (DATA_VALID === 1'b1 && dv_d === 1'b1) dv_double++;
      if (ERR === 1'b1 && er_d === 1'b1) er_double++;
      if (ERR === 1'b1 && DATA_VALID !== 1'b1) err_alone++;
      dv_d = DATA_VALID;
      er_d = ERR;
   end

   function automatic ev_t get_ev(input int i);
      ev_t ev;
      ev = '{8'hxx, 1'bx, -1};
      if (base + i < evq.size()) ev = evq[base + i];
      return ev;
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      PORT_IN = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      base = evq.size();
   endtask

   task automatic drive(input logic lvl, input int n);
      PORT_IN = lvl;
      repeat (n * TD) @(negedge CLK);
   endtask

   // One-CLK pulse of lvl placed away from the tick sampling point, then one tick of ~lvl
   task automatic glitch(input logic lvl);
      PORT_IN = lvl;
      @(negedge CLK);
      PORT_IN = ~lvl;
      repeat (TD - 1) @(negedge CLK);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      total++; if (DATA_OUT !== 8'h00) $display("FAIL reset_data: got %0d expected 0", DATA_OUT); else passed++;
      total++; if (DATA_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", DATA_VALID); else passed++;
      total++; if (ERR !== 1'b0) $display("FAIL reset_err: got %b expected 0", ERR); else passed++;
   endtask

   task automatic test_duty_64();
      ev_t ev;
      ev_t ev0;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 64);
         drive(1'b0, 192);
      end
      drive(1'b1, 4);
      total++; if (evq.size() - base !== 3) $display("FAIL duty64_count: got %0d expected 3", evq.size() - base); else passed++;
      for (int i = 0; i < 3; i++) begin
         ev = get_ev(i);
         total++; if (ev.d !== 8'd64) $display("FAIL duty64_data%0d: got %0d expected 64", i, ev.d); else passed++;
         total++; if (ev.e !== 1'b0) $display("FAIL duty64_err%0d: got %b expected 0", i, ev.e); else passed++;
      end
      ev0 = get_ev(0);
      ev  = get_ev(1);
      total++; if (ev.c - ev0.c !== 1024) $display("FAIL duty64_gap: got %0d expected 1024", ev.c - ev0.c); else passed++;
   endtask

   task automatic test_idle_timeout();
      ev_t ev;
      do_reset();
      drive(1'b0, 600);
      total++; if (evq.size() - base !== 2) $display("FAIL idle_count: got %0d expected 2", evq.size() - base); else passed++;
      for (int i = 0; i < 2; i++) begin
         ev = get_ev(i);
         total++; if (ev.d !== 8'd0) $display("FAIL idle_data%0d: got %0d expected 0", i, ev.d); else passed++;
         total++; if (ev.e !== CHK) $display("FAIL idle_err%0d: got %b expected %b", i, ev.e, CHK); else passed++;
         total++;
         if (ev.c < 1033 + i * 1032 || ev.c > 1036 + i * 1032)
            $display("FAIL idle_time%0d: got cycle %0d expected %0d..%0d", i, ev.c, 1033 + i * 1032, 1036 + i * 1032);
         else passed++;
      end
   endtask

   task automatic test_full_duty();
      ev_t ev;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 255);
         drive(1'b0, 1);
      end
      drive(1'b1, 2);
      total++; if (evq.size() - base !== 3) $display("FAIL full_count: got %0d expected 3", evq.size() - base); else passed++;
      for (int i = 0; i < 3; i++) begin
         ev = get_ev(i);
         total++; if (ev.d !== 8'd255) $display("FAIL full_data%0d: got %0d expected 255", i, ev.d); else passed++;
         total++; if (ev.e !== 1'b0) $display("FAIL full_err%0d: got %b expected 0", i, ev.e); else passed++;
      end
      do_reset();
      drive(1'b1, 600);
      total++; if (evq.size() - base !== 2) $display("FAIL stuckhi_count: got %0d expected 2", evq.size() - base); else passed++;
      for (int i = 0; i < 2; i++) begin
         ev = get_ev(i);
         total++; if (ev.d !== 8'd255) $display("FAIL stuckhi_data%0d: got %0d expected 255", i, ev.d); else passed++;
         total++; if (ev.e !== CHK) $display("FAIL stuckhi_err%0d: got %b expected %b", i, ev.e, CHK); else passed++;
      end
      ev = get_ev(0);
      total++;
      if (ev.c < 1033 || ev.c > 1036) $display("FAIL stuckhi_time: got cycle %0d expected 1033..1036", ev.c);
      else passed++;
   endtask

   task automatic test_period();
      ev_t ev;
      do_reset();
      drive(1'b1, 100);
      drive(1'b0, 200);
      drive(1'b1, 100);
      drive(1'b0, 150);
      drive(1'b1, 2);
      total++; if (evq.size() - base !== 2) $display("FAIL period_count: got %0d expected 2", evq.size() - base); else passed++;
      ev = get_ev(0);
      total++; if (ev.d !== 8'd0) $display("FAIL long_data: got %0d expected 0", ev.d); else passed++;
      total++; if (ev.e !== CHK) $display("FAIL long_err: got %b expected %b", ev.e, CHK); else passed++;
      ev = get_ev(1);
      total++; if (ev.d !== 8'd100) $display("FAIL short_data: got %0d expected 100", ev.d); else passed++;
      total++; if (ev.e !== CHK) $display("FAIL short_err: got %b expected %b", ev.e, CHK); else passed++;
   endtask

   task automatic test_reset_mid();
      ev_t ev;
      do_reset();
      drive(1'b1, 128);
      drive(1'b0, 128);
      drive(1'b1, 100);
      total++; if (evq.size() - base !== 1) $display("FAIL mid_pre_count: got %0d expected 1", evq.size() - base); else passed++;
      total++; if (DATA_OUT !== 8'd128) $display("FAIL mid_pre_data: got %0d expected 128", DATA_OUT); else passed++;
      do_reset();
      total++; if (DATA_OUT !== 8'h00) $display("FAIL mid_rst_data: got %0d expected 0", DATA_OUT); else passed++;
      total++; if (DATA_VALID !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", DATA_VALID); else passed++;
      total++; if (ERR !== 1'b0) $display("FAIL mid_rst_err: got %b expected 0", ERR); else passed++;
      drive(1'b1, 128);
      drive(1'b0, 128);
      drive(1'b1, 2);
      total++; if (evq.size() - base !== 1) $display("FAIL mid_post_count: got %0d expected 1", evq.size() - base); else passed++;
      ev = get_ev(0);
      total++; if (ev.d !== 8'd128) $display("FAIL mid_post_data: got %0d expected 128", ev.d); else passed++;
      total++; if (ev.e !== 1'b0) $display("FAIL mid_post_err: got %b expected 0", ev.e); else passed++;
   endtask

   task automatic test_glitch();
      ev_t ev;
      do_reset();
      drive(1'b1, 64);
      drive(1'b0, 100);
      glitch(1'b1);
      drive(1'b0, 91);
      drive(1'b1, 30);
      glitch(1'b0);
      drive(1'b1, 33);
      drive(1'b0, 192);
      drive(1'b1, 2);
      total++; if (evq.size() - base !== 2) $display("FAIL glitch_count: got %0d expected 2", evq.size() - base); else passed++;
      for (int i = 0; i < 2; i++) begin
         ev = get_ev(i);
         total++; if (ev.d !== 8'd64) $display("FAIL glitch_data%0d: got %0d expected 64", i, ev.d); else passed++;
         total++; if (ev.e !== 1'b0) $display("FAIL glitch_err%0d: got %b expected 0", i, ev.e); else passed++;
      end
   endtask

   task automatic test_strobes();
      total++; if (dv_double !== 0) $display("FAIL valid_width: got %0d long pulses expected 0", dv_double); else passed++;
      total++; if (er_double !== 0) $display("FAIL err_width: got %0d long pulses expected 0", er_double); else passed++;
      total++; if (err_alone !== 0) $display("FAIL err_alone: got %0d lone pulses expected 0", err_alone); else passed++;
   endtask

   initial begin
      test_reset();
      test_duty_64();
      test_idle_timeout();
      test_full_duty();
      test_period();
      test_reset_mid();
      test_glitch();
      test_strobes();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
